switch_alloc: RTL and testbench
===============================

SWITCH_ALLOC -- requirements
Module: switch_alloc

Interface
REQ-001 Parameter RR_EN, default 1, meaning: 1 = round-robin arbitration per output; 0 = fixed priority L>N>E>S>W.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-low; sampled on rising edge of clk.
REQ-004 request_L/N/E/S/W  input  3 each  destination output requested by that input's head flit; 000=L, 001=N, 010=E, 011=S, 100=W, 111=idle.
REQ-005 tail_L/N/E/S/W  input  1 each  flit currently presented at that input is the last flit of its packet.
REQ-006 ready_L/N/E/S/W  input  1 each  downstream of that output can accept a flit this cycle.
REQ-007 sel_L/N/E/S/W  output  3 each  index of the input connected to that output, same encoding as request; 111 = unconnected; registered.
REQ-008 grant_L/N/E/S/W  output  1 each  the flit at that input is transferred through the switch this cycle; combinational from state and inputs.

Function
REQ-009 Codes 101 and 110 on any request shall be treated as idle.
REQ-010 Each output o shall hold state IDLE or LOCKED, an owner index (0..4) and a round-robin pointer ptr_o (0..4).
REQ-011 sel_o shall equal owner when LOCKED, 111 when IDLE.
REQ-012 IDLE, at least one input requesting o: at the clock edge go LOCKED; owner = first requesting input at or after ptr_o, scanning upward and wrapping 4->0 (RR_EN=1), or lowest index (RR_EN=0).
REQ-013 On a lock, ptr_o shall load (winner+1) mod 5; ptr_o otherwise unchanged.
REQ-014 IDLE, no requester: remain IDLE.
REQ-015 grant_i = 1 iff some output o is LOCKED with owner i, request_i == o and ready_o == 1; otherwise 0.
REQ-016 Because each input names one output, at most one output shall grant a given input per cycle.
REQ-017 LOCKED, grant of the owner with its tail high: return to IDLE at that edge; re-arbitration happens in the following IDLE cycle (one idle cycle between packets on an output).
REQ-018 LOCKED, no grant (ready_o low, or owner request not o): remain LOCKED, same owner; no flit is lost or granted.
REQ-019 Allocation latency: request first seen at edge k -> sel_o valid and grant possible in cycle k+1.
REQ-020 Simultaneous lock decisions on different outputs are independent and shall all take effect at the same edge.
REQ-021 A requester not chosen shall keep asserting; the block shall not drop or queue requests internally.

Reset
REQ-022 rst low at a rising edge: every output IDLE, all owners 0, all ptr_o 0, all sel 111.
REQ-023 While rst is low all grant outputs shall be 0, regardless of other inputs.
REQ-024 Reset asserted mid-packet shall abandon every lock at that edge; after release arbitration restarts from ptr 0.

Verification
REQ-025 rst low 2 cycles, all requests 111 -> all sel = 111, all grant = 0; stays so after release.
REQ-026 request_L=000, tail_L=1, ready_L=1 from cycle 0 -> cycle 1: sel_L=000, grant_L=1; cycle 2: sel_L=111; cycle 3: sel_L=000 again (re-lock).
REQ-027 request_N=000 and request_E=000 together, ptr_L=0, tail=1 -> N locks first (sel_L=001), ptr_L=2; after N tail and one idle cycle E locks (sel_L=010), ptr_L=3.
REQ-028 3-flit packet from S to W (request_S=100), ready_W low in flit 2 -> grant_S=0 that cycle, sel_W stays 011; lock released only after tail flit granted.
REQ-029 request_W=101 or 110 for 4 cycles -> no output locks, grant_W=0.
REQ-030 Lock N->E mid-packet, rst low one edge -> sel_E=111, grant_N=0 immediately; after release new request re-locks with ptr_E from 0.

Source files
------------

// File: rtl/switch_alloc.sv
// Five-port wormhole switch allocator: each output locks to one input for a whole
// packet, chosen round-robin (RR_EN=1) or by fixed priority L>N>E>S>W (RR_EN=0).
module switch_alloc #(
  parameter int RR_EN = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] request_L,
  input  logic [2:0] request_N,
  input  logic [2:0] request_E,
  input  logic [2:0] request_S,
  input  logic [2:0] request_W,
  input  logic       tail_L,
  input  logic       tail_N,
  input  logic       tail_E,
  input  logic       tail_S,
  input  logic       tail_W,
  input  logic       ready_L,
  input  logic       ready_N,
  input  logic       ready_E,
  input  logic       ready_S,
  input  logic       ready_W,
  output logic [2:0] sel_L,
  output logic [2:0] sel_N,
  output logic [2:0] sel_E,
  output logic [2:0] sel_S,
  output logic [2:0] sel_W,
  output logic       grant_L,
  output logic       grant_N,
  output logic       grant_E,
  output logic       grant_S,
  output logic       grant_W
);
  typedef enum logic {ST_IDLE, ST_LOCKED} state_t;

  localparam int unsigned NP = 5;
  localparam logic [2:0] SEL_NONE = 3'b111;

  logic [2:0]    w_req       [NP];
  logic [NP-1:0] w_mask      [NP];
  logic [2:0]    w_winner    [NP];
  logic [NP-1:0] w_tail, w_ready, w_grant, w_any, w_ogrant;
  state_t        r_state     [NP];
  state_t        w_state_nxt [NP];
  logic [2:0]    r_owner     [NP];
  logic [2:0]    w_owner_nxt [NP];
  logic [2:0]    r_ptr       [NP];
  logic [2:0]    w_ptr_nxt   [NP];
  logic [2:0]    r_sel       [NP];
  logic [2:0]    w_sel_nxt   [NP];

  assign w_req[0] = request_L;
  assign w_req[1] = request_N;
  assign w_req[2] = request_E;
  assign w_req[3] = request_S;
  assign w_req[4] = request_W;
  assign w_tail   = {tail_W, tail_S, tail_E, tail_N, tail_L};
  assign w_ready  = {ready_W, ready_S, ready_E, ready_N, ready_L};

  // Scan downward from ptr+4 to ptr so the last hit is the first requester at or after ptr.
  function automatic logic [2:0] rr_pick(input logic [NP-1:0] mask, input logic [2:0] ptr);
    logic [2:0] win;
    logic [3:0] idx;
    win = '0;
    for (int unsigned k = 0; k < NP; k++) begin
      idx = {1'b0, ptr} + 4'(NP - 1 - k);
      if (idx >= 4'd5) idx = idx - 4'd5;
      if (mask[idx[2:0]]) win = idx[2:0];
    end
    return win;
  endfunction

  // Codes 101..111 never match an output index, so they fall out as idle here.
  always_comb begin
    for (int unsigned o = 0; o < NP; o++) begin
      for (int unsigned i = 0; i < NP; i++) begin
        w_mask[o][i] = (w_req[i] == 3'(o));
      end
      w_any[o]    = |w_mask[o];
      w_winner[o] = rr_pick(w_mask[o], (RR_EN != 0) ? r_ptr[o] : 3'd0);
      w_ogrant[o] = (r_state[o] == ST_LOCKED) && w_mask[o][r_owner[o]] && w_ready[o];
    end
  end

  always_comb begin
    w_grant = '0;
    for (int unsigned o = 0; o < NP; o++) begin
      for (int unsigned i = 0; i < NP; i++) begin
        if (w_ogrant[o] && (r_owner[o] == 3'(i))) w_grant[i] = 1'b1;
      end
    end
    if (!rst) w_grant = '0;
  end

  always_comb begin
    for (int unsigned o = 0; o < NP; o++) begin
      w_state_nxt[o] = r_state[o];
      w_owner_nxt[o] = r_owner[o];
      w_ptr_nxt[o]   = r_ptr[o];
      case (r_state[o])
        ST_IDLE: begin
          if (w_any[o]) begin
            w_state_nxt[o] = ST_LOCKED;
            w_owner_nxt[o] = w_winner[o];
            w_ptr_nxt[o]   = (w_winner[o] == 3'd4) ? 3'd0 : w_winner[o] + 3'd1;
          end
        end
        ST_LOCKED: begin
          if (w_ogrant[o] && w_tail[r_owner[o]]) w_state_nxt[o] = ST_IDLE;
        end
        default: w_state_nxt[o] = ST_IDLE;
      endcase
      w_sel_nxt[o] = (w_state_nxt[o] == ST_LOCKED) ? w_owner_nxt[o] : SEL_NONE;
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned o = 0; o < NP; o++) begin
      if (!rst) begin
        r_state[o] <= ST_IDLE;
        r_owner[o] <= '0;
        r_ptr[o]   <= '0;
        r_sel[o]   <= SEL_NONE;
      end else begin
        r_state[o] <= w_state_nxt[o];
        r_owner[o] <= w_owner_nxt[o];
        r_ptr[o]   <= w_ptr_nxt[o];
        r_sel[o]   <= w_sel_nxt[o];
      end
    end
  end

  assign sel_L   = r_sel[0];
  assign sel_N   = r_sel[1];
  assign sel_E   = r_sel[2];
  assign sel_S   = r_sel[3];
  assign sel_W   = r_sel[4];
  assign grant_L = w_grant[0];
  assign grant_N = w_grant[1];
  assign grant_E = w_grant[2];
  assign grant_S = w_grant[3];
  assign grant_W = w_grant[4];
endmodule

// File: tb/tb_switch_alloc.sv
// Bench for switch_alloc: directed vector table plus randomized traffic against a
// per-output lock/owner/pointer reference model, for both arbitration modes.
module tb_switch_alloc;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [2:0] req [5];
  logic [4:0] tail, rdy;
  logic [2:0] sel_rr [5];
  logic [2:0] sel_fp [5];
  logic       gnt_rr [5];
  logic       gnt_fp [5];

  int n_tests = 0;
  int n_fail  = 0;

  switch_alloc #(.RR_EN(1)) dut_rr (
    .clk(clk), .rst(rst),
    .request_L(req[0]), .request_N(req[1]), .request_E(req[2]), .request_S(req[3]), .request_W(req[4]),
    .tail_L(tail[0]), .tail_N(tail[1]), .tail_E(tail[2]), .tail_S(tail[3]), .tail_W(tail[4]),
    .ready_L(rdy[0]), .ready_N(rdy[1]), .ready_E(rdy[2]), .ready_S(rdy[3]), .ready_W(rdy[4]),
    .sel_L(sel_rr[0]), .sel_N(sel_rr[1]), .sel_E(sel_rr[2]), .sel_S(sel_rr[3]), .sel_W(sel_rr[4]),
    .grant_L(gnt_rr[0]), .grant_N(gnt_rr[1]), .grant_E(gnt_rr[2]), .grant_S(gnt_rr[3]), .grant_W(gnt_rr[4])
  );

  switch_alloc #(.RR_EN(0)) dut_fp (
    .clk(clk), .rst(rst),
    .request_L(req[0]), .request_N(req[1]), .request_E(req[2]), .request_S(req[3]), .request_W(req[4]),
    .tail_L(tail[0]), .tail_N(tail[1]), .tail_E(tail[2]), .tail_S(tail[3]), .tail_W(tail[4]),
    .ready_L(rdy[0]), .ready_N(rdy[1]), .ready_E(rdy[2]), .ready_S(rdy[3]), .ready_W(rdy[4]),
    .sel_L(sel_fp[0]), .sel_N(sel_fp[1]), .sel_E(sel_fp[2]), .sel_S(sel_fp[3]), .sel_W(sel_fp[4]),
    .grant_L(gnt_fp[0]), .grant_N(gnt_fp[1]), .grant_E(gnt_fp[2]), .grant_S(gnt_fp[3]), .grant_W(gnt_fp[4])
  );

  // Vectors pack ports as {W,S,E,N,L}; a row's sel/grant are what is seen during that cycle.
  typedef struct {
    logic        rst;
    logic [14:0] req;
    logic [4:0]  tail;
    logic [4:0]  rdy;
    logic [14:0] esel;
    logic [4:0]  egnt;
  } vec_t;

  vec_t tv [40];
  int   nv = 0;

  task automatic add(input logic r, input logic [14:0] q, input logic [4:0] t,
                     input logic [4:0] y, input logic [14:0] s, input logic [4:0] g);
    tv[nv].rst  = r;
    tv[nv].req  = q;
    tv[nv].tail = t;
    tv[nv].rdy  = y;
    tv[nv].esel = s;
    tv[nv].egnt = g;
    nv++;
  endtask

  // Reference model, index 0 = fixed priority, 1 = round-robin.
  int m_lock [2][5];
  int m_own  [2][5];
  int m_ptr  [2][5];

  function automatic int model_grant(input int m, input int i);
    int d;
    d = int'(req[i]);
    if (!rst || d > 4) return 0;
    return (m_lock[m][d] != 0 && m_own[m][d] == i && rdy[d]) ? 1 : 0;
  endfunction

  function automatic void model_exp(input int m, output logic [14:0] es, output logic [4:0] eg);
    for (int o = 0; o < 5; o++) es[3*o +: 3] = (m_lock[m][o] != 0) ? 3'(m_own[m][o]) : 3'b111;
    for (int i = 0; i < 5; i++) eg[i] = (model_grant(m, i) != 0);
  endfunction

  function automatic void model_step(input int m);
    int own, c;
    for (int o = 0; o < 5; o++) begin
      if (!rst) begin
        m_lock[m][o] = 0;
        m_own[m][o]  = 0;
        m_ptr[m][o]  = 0;
      end else if (m_lock[m][o] != 0) begin
        own = m_own[m][o];
        if (int'(req[own]) == o && rdy[o] && tail[own]) m_lock[m][o] = 0;
      end else begin
        for (int k = 0; k < 5; k++) begin
          c = (m == 1) ? (m_ptr[m][o] + k) % 5 : k;
          if (int'(req[c]) == o) begin
            m_lock[m][o] = 1;
            m_own[m][o]  = c;
            m_ptr[m][o]  = (c + 1) % 5;
            break;
          end
        end
      end
    end
  endfunction

  task automatic check(input string nm, input int m, input logic [14:0] esel, input logic [4:0] egnt);
    logic [14:0] gs;
    logic [4:0]  gg;
    for (int i = 0; i < 5; i++) begin
      gs[3*i +: 3] = (m == 1) ? sel_rr[i] : sel_fp[i];
      gg[i]        = (m == 1) ? gnt_rr[i] : gnt_fp[i];
    end
    n_tests++;
    if (gs !== esel) begin
      n_fail++;
      $display("FAIL %s rr=%0d sel {W,S,E,N,L}: got %h want %h", nm, m, gs, esel);
    end
    n_tests++;
    if (gg !== egnt) begin
      n_fail++;
      $display("FAIL %s rr=%0d grant {W,S,E,N,L}: got %b want %b", nm, m, gg, egnt);
    end
  endtask

  logic [14:0] es;
  logic [4:0]  eg;
  logic [4:0]  done;

  initial begin
    // reset and idle
    add(0, 15'h7FFF, 5'h00, 5'h1F, 15'h7FFF, 5'h00);
    add(1, 15'h7FFF, 5'h00, 5'h1F, 15'h7FFF, 5'h00);
    add(1, 15'h7FFF, 5'h00, 5'h1F, 15'h7FFF, 5'h00);
    // single-flit packets L->L: lock, release, one idle cycle, re-lock
    add(1, 15'h7FF8, 5'h01, 5'h1F, 15'h7FFF, 5'h00);
    add(1, 15'h7FF8, 5'h01, 5'h1F, 15'h7FF8, 5'h01);
    add(1, 15'h7FF8, 5'h01, 5'h1F, 15'h7FFF, 5'h00);
    add(1, 15'h7FF8, 5'h01, 5'h1F, 15'h7FF8, 5'h01);
    // reset, then N and E contend for L: N first, E after one idle cycle
    add(0, 15'h7FFF, 5'h00, 5'h1F, 15'h7FFF, 5'h00);
    add(1, 15'h7E07, 5'h06, 5'h1F, 15'h7FFF, 5'h00);
    add(1, 15'h7E07, 5'h06, 5'h1F, 15'h7FF9, 5'h02);
    add(1, 15'h7E3F, 5'h06, 5'h1F, 15'h7FFF, 5'h00);
    add(1, 15'h7E3F, 5'h06, 5'h1F, 15'h7FFA, 5'h04);
    add(1, 15'h7FFF, 5'h00, 5'h1F, 15'h7FFF, 5'h00);
    // 3-flit S->W packet with a ready_W stall on flit 2
    add(1, 15'h79FF, 5'h00, 5'h1F, 15'h7FFF, 5'h00);
    add(1, 15'h79FF, 5'h00, 5'h1F, 15'h3FFF, 5'h08);
    add(1, 15'h79FF, 5'h00, 5'h0F, 15'h3FFF, 5'h00);
    add(1, 15'h79FF, 5'h00, 5'h1F, 15'h3FFF, 5'h08);
    add(1, 15'h79FF, 5'h08, 5'h1F, 15'h3FFF, 5'h08);
    add(1, 15'h7FFF, 5'h00, 5'h1F, 15'h7FFF, 5'h00);
    // W requests with illegal codes 101/110 never lock
    add(1, 15'h5FFF, 5'h1F, 5'h1F, 15'h7FFF, 5'h00);
    add(1, 15'h6FFF, 5'h1F, 5'h1F, 15'h7FFF, 5'h00);
    add(1, 15'h5FFF, 5'h1F, 5'h1F, 15'h7FFF, 5'h00);
    add(1, 15'h6FFF, 5'h1F, 5'h1F, 15'h7FFF, 5'h00);
    add(1, 15'h7FFF, 5'h00, 5'h1F, 15'h7FFF, 5'h00);
    // N->E mid-packet reset; afterwards N and S contend and pointer 0 favours N
    add(1, 15'h7FD7, 5'h00, 5'h1F, 15'h7FFF, 5'h00);
    add(1, 15'h7FD7, 5'h00, 5'h1F, 15'h7E7F, 5'h02);
    add(0, 15'h7FD7, 5'h00, 5'h1F, 15'h7E7F, 5'h00);
    add(1, 15'h75D7, 5'h00, 5'h1F, 15'h7FFF, 5'h00);
    add(1, 15'h75D7, 5'h00, 5'h1F, 15'h7E7F, 5'h02);

    rst  = 1'b0;
    tail = '0;
    rdy  = '1;
    for (int i = 0; i < 5; i++) req[i] = 3'b111;
    repeat (2) @(posedge clk);
    #1;

    for (int r = 0; r < nv; r++) begin
      rst  = tv[r].rst;
      tail = tv[r].tail;
      rdy  = tv[r].rdy;
      for (int i = 0; i < 5; i++) req[i] = tv[r].req[3*i +: 3];
      @(negedge clk);
      check($sformatf("vec%0d", r), 1, tv[r].esel, tv[r].egnt);
      check($sformatf("vec%0d", r), 0, tv[r].esel, tv[r].egnt);
      @(posedge clk);
      #1;
    end

    rst = 1'b0;
    for (int i = 0; i < 5; i++) req[i] = 3'b111;
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
    rst  = 1'b1;
    done = '1;

    for (int n = 0; n < 500; n++) begin
      @(negedge clk);
      model_exp(1, es, eg);
      check($sformatf("rand%0d", n), 1, es, eg);
      for (int i = 0; i < 5; i++) done[i] = eg[i] && tail[i];
      model_exp(0, es, eg);
      check($sformatf("rand%0d", n), 0, es, eg);
      @(posedge clk);
      model_step(0);
      model_step(1);
      #1;
      rst = ($urandom_range(0, 59) != 0);
      for (int i = 0; i < 5; i++) begin
        if (done[i] || req[i] > 3'd4 || !rst) begin
          if ($urandom_range(0, 9) < 2) req[i] = 3'($urandom_range(5, 7));
          else                          req[i] = 3'($urandom_range(0, 4));
        end
        tail[i] = ($urandom_range(0, 2) == 0);
        rdy[i]  = ($urandom_range(0, 3) != 0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
